// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: grants the shared MAR/MDR/memory port to fetch (0), execute (1) or I/O (2)
// and runs the full MFC handshake. Define ARB_ROUND_ROBIN_EN for round-robin; default is fixed 1>0>2.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [2:0] rw_req,
  input  logic       mfc,
  output logic [2:0] gnt,
  output logic       mar_in,
  output logic       mem_en,
  output logic       mem_rw,
  output logic       mdr_in,
  output logic [2:0] done,
  output logic       err,
  output logic [1:0] err_id,
  output logic       busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT   = 3'd1;
  localparam logic [2:0] S_ACCESS  = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  logic [2:0]       r_state, w_next;
  logic [1:0]       r_id, w_win_id, w_id;
  logic             r_rw, w_rw;
  logic [2:0]       w_id_oh;
  logic [CNT_W-1:0] r_cnt, w_cnt_inc;
  logic             w_cnt_hit;

  logic [2:0] r_gnt, r_done;
  logic       r_mar_in, r_mem_en, r_mem_rw, r_mdr_in, r_err, r_busy;
  logic [1:0] r_err_id;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] r_last, w_c0, w_c1, w_c2;

  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id >= 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

  // Search starts just after the last granted id and wraps through all three.
  always_comb begin
    w_c0 = next_id(r_last);
    w_c1 = next_id(w_c0);
    w_c2 = next_id(w_c1);
    if (req[w_c0])      w_win_id = w_c0;
    else if (req[w_c1]) w_win_id = w_c1;
    else                w_win_id = w_c2;
  end

  always_ff @(posedge clk) begin
    if (rst)                           r_last <= 2'd2;
    else if (r_state == S_IDLE && |req) r_last <= w_win_id;
  end
`else
  always_comb begin
    w_win_id = req[1] ? 2'd1 : (req[0] ? 2'd0 : 2'd2);
  end
`endif

  // The winner is latched on the same edge that enters GRANT, so outputs decode from it directly.
  assign w_id      = (r_state == S_IDLE) ? w_win_id : r_id;
  assign w_rw      = (r_state == S_IDLE) ? rw_req[w_win_id] : r_rw;
  assign w_id_oh   = 3'b001 << w_id;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_cnt_hit = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (|req) w_next = S_GRANT;
      S_GRANT:   w_next = S_ACCESS;
      S_ACCESS: begin
        if (mfc)            w_next = S_RELEASE;
        else if (w_cnt_hit) w_next = S_ERROR;
      end
      S_RELEASE: begin
        if (!mfc)           w_next = S_DONE;
        else if (w_cnt_hit) w_next = S_ERROR;
      end
      S_DONE:    w_next = S_IDLE;
      S_ERROR:   w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_id     <= 2'd0;
      r_rw     <= 1'b0;
      r_cnt    <= '0;
      r_gnt    <= 3'b000;
      r_mar_in <= 1'b0;
      r_mem_en <= 1'b0;
      r_mem_rw <= 1'b0;
      r_mdr_in <= 1'b0;
      r_done   <= 3'b000;
      r_err    <= 1'b0;
      r_err_id <= 2'd0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && |req) begin
        r_id <= w_win_id;
        r_rw <= rw_req[w_win_id];
      end
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state == S_ACCESS || r_state == S_RELEASE)
        r_cnt <= w_cnt_inc;

      r_gnt    <= (w_next inside {S_GRANT, S_ACCESS, S_RELEASE, S_DONE}) ? w_id_oh : 3'b000;
      r_mar_in <= (w_next == S_GRANT);
      r_mem_en <= (w_next == S_ACCESS);
      r_mem_rw <= (w_next == S_ACCESS) && w_rw;
      // MDR captures only on the ACCESS->RELEASE step, i.e. the first RELEASE cycle.
      r_mdr_in <= (w_next == S_RELEASE) && (r_state == S_ACCESS) && r_rw;
      r_done   <= (w_next == S_DONE) ? w_id_oh : 3'b000;
      r_err    <= (w_next == S_ERROR);
      if (w_next == S_ERROR) r_err_id <= r_id;
      r_busy   <= (w_next != S_IDLE);
    end
  end

  assign gnt    = r_gnt;
  assign mar_in = r_mar_in;
  assign mem_en = r_mem_en;
  assign mem_rw = r_mem_rw;
  assign mdr_in = r_mdr_in;
  assign done   = r_done;
  assign err    = r_err;
  assign err_id = r_err_id;
  assign busy   = r_busy;

endmodule
